// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load/store unit mask scheduling path.
package vlsu_pkg;

  localparam int unsigned MaskOrdDep   = 4;
  localparam int unsigned MaskOrdBeatW = 16;

  // One pending masked instruction: consumer and number of mask beats it takes.
  typedef struct packed {
    logic                    is_load;
    logic [MaskOrdBeatW-1:0] beats;
  } mask_ord_t;

endpackage

// File: rtl/vlsu_mask_ord_fifo.sv
// Order queue of pending masked instructions; head is presented from storage.
module vlsu_mask_ord_fifo
  import vlsu_pkg::*;
#(
  parameter int unsigned Depth = MaskOrdDep
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  mask_ord_t push_data_i,
  input  logic      pop_i,
  output mask_ord_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mask_ord_t       mem_q [Depth];
  mask_ord_t       mem_d [Depth];
  logic            push_ok;
  logic            pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  // Next-state for pointers, occupancy and storage; pointers wrap naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful behind the occupancy count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vlsu_mask_sched.sv
// Joins per-lane mask fragments into beats and routes them to load/store in order.
module vlsu_mask_sched
  import vlsu_pkg::*;
#(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned StrbW   = 16,
  parameter int unsigned QDepth  = MaskOrdDep,
  parameter int unsigned BeatW   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic                     enq_is_load_i,
  input  logic [BeatW-1:0]         enq_beats_i,
  input  logic [NrLanes-1:0]       lane_mask_valid_i,
  input  logic [NrLanes*StrbW-1:0] lane_mask_bits_i,
  output logic [NrLanes-1:0]       lane_mask_ready_o,
  output logic                     ld_mask_valid_o,
  input  logic                     ld_mask_ready_i,
  output logic                     st_mask_valid_o,
  input  logic                     st_mask_ready_i,
  output logic [NrLanes*StrbW-1:0] mask_bits_o,
  output logic                     busy_o
);

  mask_ord_t        push_data;
  mask_ord_t        head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             beat_avail;
  logic             fire;
  logic             last_beat;
  logic [BeatW-1:0] head_beats;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;

  // Zero-beat instructions are acknowledged but never queued.
  assign push              = enq_valid_i & enq_ready_o & (enq_beats_i != '0);
  assign push_data.is_load = enq_is_load_i;
  assign push_data.beats   = MaskOrdBeatW'(enq_beats_i);

  vlsu_mask_ord_fifo #(
    .Depth(QDepth)
  ) i_ord_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign enq_ready_o = ~fifo_full;
  assign busy_o      = ~fifo_empty;
  assign mask_bits_o = lane_mask_bits_i;
  assign beat_avail  = &lane_mask_valid_i;
  assign head_beats  = BeatW'(head.beats);

  // Beat select: valids depend only on queue head and lane arrival, never on ready.
  always_comb begin
    ld_mask_valid_o = 1'b0;
    st_mask_valid_o = 1'b0;
    if (!fifo_empty && beat_avail) begin
      ld_mask_valid_o = head.is_load;
      st_mask_valid_o = ~head.is_load;
    end
    fire              = (ld_mask_valid_o & ld_mask_ready_i) | (st_mask_valid_o & st_mask_ready_i);
    lane_mask_ready_o = {NrLanes{fire}};
  end

  // Beat counting against the head entry; the final beat retires the head.
  always_comb begin
    last_beat  = (beat_cnt_q == head_beats - BeatW'(1));
    pop        = fire & last_beat;
    beat_cnt_d = beat_cnt_q;
    if (fire) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + BeatW'(1);
    end
  end

  // Beat counter register, cleared asynchronously with the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
